// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level sequencer: splits START/STOP/WRITE/READ into four prescaled
// phases driving the open-drain SCL/SDA enables, with stretching and arbitration.
module i2c_bit_ctrl #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] clk_cnt,
    input  logic [1:0]            cmd,
    input  logic                  cmd_valid,
    input  logic                  din,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  cmd_ack,
    output logic                  dout,
    output logic                  busy,
    output logic                  arb_lost,
    output logic                  scl_oen,
    output logic                  sda_oen
);

    // Phases of each command are consecutive so "next phase" is state + 1.
    typedef enum logic [4:0] {
        IDLE,
        START_A, START_B, START_C, START_D,
        STOP_A,  STOP_B,  STOP_C,  STOP_D,
        WR_A,    WR_B,    WR_C,    WR_D,
        RD_A,    RD_B,    RD_C,    RD_D
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  din_q, din_d;
    logic                  scl_oen_q, scl_oen_d;
    logic                  sda_oen_q, sda_oen_d;
    logic                  cmd_ack_q, cmd_ack_d;
    logic                  arb_lost_q, arb_lost_d;
    logic                  busy_q, busy_d;
    logic                  dout_q, dout_d;

    logic                  accept;
    logic                  stretch;
    logic                  arb_hit;
    logic [1:0]            oen_next;
    state_t                state_next;

    function automatic state_t first_phase(input logic [1:0] c);
        case (c)
            CMD_START: first_phase = START_A;
            CMD_STOP:  first_phase = STOP_A;
            CMD_WRITE: first_phase = WR_A;
            default:   first_phase = RD_A;
        endcase
    endfunction

    function automatic logic is_last_phase(input state_t s);
        is_last_phase = (s == START_D) || (s == STOP_D) || (s == WR_D) || (s == RD_D);
    endfunction

    // Returns {scl_oen, sda_oen} applied when a phase is entered.
    function automatic logic [1:0] phase_oen(input state_t s, input logic d);
        case (s)
            START_A, START_B: phase_oen = 2'b11;
            START_C:          phase_oen = 2'b10;
            START_D:          phase_oen = 2'b00;
            STOP_A:           phase_oen = 2'b00;
            STOP_B, STOP_C:   phase_oen = 2'b10;
            STOP_D:           phase_oen = 2'b11;
            WR_A, WR_D:       phase_oen = {1'b0, d};
            WR_B, WR_C:       phase_oen = {1'b1, d};
            RD_A, RD_D:       phase_oen = 2'b01;
            RD_B, RD_C:       phase_oen = 2'b11;
            default:          phase_oen = 2'b11;
        endcase
    endfunction

    assign accept     = ena & cmd_valid & ~cmd_ack_q & (state_q == IDLE);
    // A released SCL that still reads low means a slave is stretching the clock.
    assign stretch    = scl_oen_q & ~scl_i;
    assign arb_hit    = ((state_q == WR_B) || (state_q == WR_C)) & din_q & ~sda_i;
    assign state_next = state_t'(state_q + 5'd1);
    assign oen_next   = phase_oen(state_next, din_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        scl_oen_d  = scl_oen_q;
        sda_oen_d  = sda_oen_q;
        cmd_ack_d  = 1'b0;
        arb_lost_d = 1'b0;
        busy_d     = busy_q;
        dout_d     = dout_q;

        if (accept) begin
            state_d                = first_phase(cmd);
            din_d                  = din;
            cnt_d                  = clk_cnt;
            {scl_oen_d, sda_oen_d} = phase_oen(first_phase(cmd), din);
        end else if ((state_q != IDLE) && ena && !stretch) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PRESCALE_W'(1);
            end else begin
                if (state_q == RD_C) begin
                    dout_d = sda_i;
                end
                if (arb_hit) begin
                    state_d                = IDLE;
                    arb_lost_d             = 1'b1;
                    busy_d                 = 1'b0;
                    {scl_oen_d, sda_oen_d} = 2'b11;
                end else if (is_last_phase(state_q)) begin
                    state_d   = IDLE;
                    cmd_ack_d = 1'b1;
                    if (state_q == START_D) begin
                        busy_d = 1'b1;
                    end else if (state_q == STOP_D) begin
                        busy_d = 1'b0;
                    end
                end else begin
                    state_d                = state_next;
                    cnt_d                  = clk_cnt;
                    {scl_oen_d, sda_oen_d} = oen_next;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            din_q      <= 1'b0;
            scl_oen_q  <= 1'b1;
            sda_oen_q  <= 1'b1;
            cmd_ack_q  <= 1'b0;
            arb_lost_q <= 1'b0;
            busy_q     <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            scl_oen_q  <= scl_oen_d;
            sda_oen_q  <= sda_oen_d;
            cmd_ack_q  <= cmd_ack_d;
            arb_lost_q <= arb_lost_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
        end
    end

    assign cmd_ack  = cmd_ack_q;
    assign arb_lost = arb_lost_q;
    assign busy     = busy_q;
    assign dout     = dout_q;
    assign scl_oen  = scl_oen_q;
    assign sda_oen  = sda_oen_q;

endmodule
